lpm_request_arbiter: RTL and testbench

Round-robin arbiter that shares one LPM request pipe between `NREQ` independent requesters. Each requester presents 144-bit pipe messages: a 16-bit method tag in the top bits (0 = enter, 1 = write) above a 128-bit payload. Messages are captured in one holding register per requester, granted one per cycle into a registered output stage, and forwarded with the winning requester's index. The block sits between the host/software request ports and the pipe-to-method demultiplexer that drives the LPM core.

---
 rtl/lpm_request_arbiter_if.sv | 28 ++
 rtl/lpm_request_arbiter.sv | 111 +++++++++++
 tb/tb_lpm_request_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lpm_request_arbiter_if.sv
// Request/response bundle between the host request ports, the round-robin
// arbiter and the downstream pipe-to-method demultiplexer.
interface lpm_request_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 144,
   parameter int IDW   = $clog2(NREQ)
);
   logic [NREQ-1:0]       req_enq__ENA;
   logic [NREQ*WIDTH-1:0] req_enq_v;
   logic [NREQ-1:0]       req_enq__RDY;
   logic                  out_enq__ENA;
   logic [WIDTH-1:0]      out_enq_v;
   logic [IDW-1:0]        out_id;
   logic                  out_enq__RDY;
   logic [31:0]           msg_count;

   // Requester/consumer side of the arbiter
   modport master (
      output req_enq__ENA, req_enq_v, out_enq__RDY,
      input  req_enq__RDY, out_enq__ENA, out_enq_v, out_id, msg_count
   );

   // Arbiter side
   modport slave (
      input  req_enq__ENA, req_enq_v, out_enq__RDY,
      output req_enq__RDY, out_enq__ENA, out_enq_v, out_id, msg_count
   );
endinterface

// File: rtl/lpm_request_arbiter.sv
// Round-robin arbiter sharing one LPM request pipe between NREQ requesters.
// Optional macro LPM_ARB_WRITE_PRIORITY_EN: held writes (tag == 1) win arbitration.
module lpm_request_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 144,
   parameter int TAG_W = 16,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  CLK,
   input  logic                  RST,
   lpm_request_arbiter_if.slave  bus
);

   logic [NREQ-1:0]  held_q, held_d;
   logic [WIDTH-1:0] hold_v_q [NREQ];
   logic [NREQ-1:0]  cand;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_idx;
   logic             grant_any;
   logic             out_free;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [IDW-1:0]   out_idr_q, out_idr_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [31:0]      cnt_q, cnt_d;

   assign out_free = !out_valid_q || bus.out_enq__RDY;

`ifdef LPM_ARB_WRITE_PRIORITY_EN
   logic [NREQ-1:0] held_write;
   always_comb begin
      for (int i = 0; i < NREQ; i++)
         held_write[i] = held_q[i] && (hold_v_q[i][WIDTH-1 -: TAG_W] == TAG_W'(1));
      cand = (held_write != '0) ? held_write : held_q;
   end
`else
   localparam int unused_tag_w = TAG_W;
   assign cand = held_q;
`endif

   // First candidate at or after ptr, wrapping; suppressed while the output stage is blocked.
   always_comb begin
      int           idx;
      logic [IDW-1:0] idx_l;
      idx       = 0;
      idx_l     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      grant     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_l = IDW'(idx);
         if (!grant_any && cand[idx_l]) begin
            grant_any = 1'b1;
            grant_idx = idx_l;
         end
      end
      if (!out_free) grant_any = 1'b0;
      if (grant_any) grant[grant_idx] = 1'b1;
   end

   always_comb begin
      held_d      = (held_q & ~grant) | bus.req_enq__ENA;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idr_d   = out_idr_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      if (grant_any) begin
         out_valid_d = 1'b1;
         out_data_d  = hold_v_q[grant_idx];
         out_idr_d   = grant_idx;
         ptr_d       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end else if (out_valid_q && bus.out_enq__RDY) begin
         out_valid_d = 1'b0;
      end
      if (out_valid_q && bus.out_enq__RDY) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         held_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idr_q   <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
      end else begin
         held_q      <= held_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idr_q   <= out_idr_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   // NOTE: holding registers carry no reset; their contents are only observed while held_q is set.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < NREQ; i++)
         if (bus.req_enq__ENA[i]) hold_v_q[i] <= bus.req_enq_v[i*WIDTH +: WIDTH];
   end

   assign bus.req_enq__RDY = ~held_q | grant;
   assign bus.out_enq__ENA = out_valid_q;
   assign bus.out_enq_v    = out_data_q;
   assign bus.out_id       = out_idr_q;
   assign bus.msg_count    = cnt_q;

endmodule

// File: tb/tb_lpm_request_arbiter.sv
// Self-checking bench for lpm_request_arbiter: directed scenarios plus random traffic
// compared against a slot-level reference model of the arbitration rules.
module tb_lpm_request_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 144;
   localparam int TAG_W = 16;
   localparam int IDW   = 2;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 CLK = ~CLK;

   lpm_request_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   lpm_request_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TAG_W(TAG_W), .IDW(IDW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Reference model: one message slot per requester, one output slot.
   bit               m_full [NREQ];
   logic [WIDTH-1:0] m_msg  [NREQ];
   bit               m_ov;
   logic [WIDTH-1:0] m_od;
   int               m_oid;
   int               m_ptr;
   int               m_cnt;
   int               enq_total;

   logic [WIDTH-1:0] din [NREQ];
   int               got_id [$];
   logic [WIDTH-1:0] got_data [$];

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREQ; i++) m_full[i] = 0;
      m_ov = 0; m_od = '0; m_oid = 0; m_ptr = 0; m_cnt = 0; enq_total = 0;
   endtask

   function automatic bit is_write(input logic [WIDTH-1:0] m);
      logic [TAG_W-1:0] t;
      t = m[WIDTH-1 -: TAG_W];
      return t == TAG_W'(1);
   endfunction

   // Which requester wins this cycle, or -1.
   function automatic int model_grant(input logic rdy);
      bit only_writes;
      int i;
      only_writes = 0;
      if (m_ov && !rdy) return -1;
`ifdef LPM_ARB_WRITE_PRIORITY_EN
      for (int r = 0; r < NREQ; r++)
         if (m_full[r] && is_write(m_msg[r])) only_writes = 1;
`endif
      for (int off = 0; off < NREQ; off++) begin
         i = (m_ptr + off) % NREQ;
         if (m_full[i] && (!only_writes || is_write(m_msg[i]))) return i;
      end
      return -1;
   endfunction

   function automatic logic [WIDTH-1:0] rand_msg();
      logic [TAG_W-1:0] tag;
      case ($urandom_range(0, 3))
         0:       tag = '0;
         1:       tag = TAG_W'(1);
         default: tag = TAG_W'($urandom);
      endcase
      return {tag, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock cycle: drive, check pre-edge outputs against the model, advance.
   task automatic cyc(input logic [NREQ-1:0] want, input logic rdy, input logic rst);
      int              g;
      logic [NREQ-1:0] exp_rdy, ena;
      g = model_grant(rdy);
      for (int i = 0; i < NREQ; i++) exp_rdy[i] = !m_full[i] || (g == i);
      ena = want & exp_rdy;
      RST = rst;
      bus.out_enq__RDY = rdy;
      bus.req_enq__ENA = ena;
      for (int i = 0; i < NREQ; i++) bus.req_enq_v[i*WIDTH +: WIDTH] = din[i];
      #1;
      check("req_rdy",   WIDTH'(bus.req_enq__RDY), WIDTH'(exp_rdy));
      check("out_valid", WIDTH'(bus.out_enq__ENA), WIDTH'(m_ov));
      check("out_data",  bus.out_enq_v, m_od);
      check("out_id",    WIDTH'(bus.out_id), WIDTH'(m_oid));
      check("msg_count", WIDTH'(bus.msg_count), WIDTH'(m_cnt));
      if (bus.out_enq__ENA === 1'b1 && rdy) begin
         got_id.push_back(int'(bus.out_id));
         got_data.push_back(bus.out_enq_v);
      end
      if (rst) begin
         model_reset();
      end else begin
         if (m_ov && rdy) m_cnt++;
         if (g >= 0) begin
            m_od = m_msg[g]; m_oid = g; m_ov = 1; m_full[g] = 0;
            m_ptr = (g + 1) % NREQ;
         end else if (m_ov && rdy) begin
            m_ov = 0;
         end
         for (int i = 0; i < NREQ; i++)
            if (ena[i]) begin
               m_full[i] = 1; m_msg[i] = din[i]; enq_total++;
            end
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int exp_first;
      bus.req_enq__ENA = '0;
      bus.req_enq_v    = '0;
      bus.out_enq__RDY = 1'b1;
      for (int i = 0; i < NREQ; i++) din[i] = '0;

      // Reset and idle
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset();
      check("rst_rdy",   WIDTH'(bus.req_enq__RDY), WIDTH'(4'b1111));
      check("rst_valid", WIDTH'(bus.out_enq__ENA), '0);
      check("rst_count", WIDTH'(bus.msg_count), '0);
      repeat (2) cyc('0, 1'b1, 1'b0);

      // Single requester streaming
      got_id.delete(); got_data.delete();
      for (int k = 1; k <= 8; k++) begin
         din[2] = {16'h0, 128'(k)};
         cyc(4'b0100, 1'b1, 1'b0);
      end
      repeat (3) cyc('0, 1'b1, 1'b0);
      check("stream_n", WIDTH'(got_id.size()), WIDTH'(8));
      for (int k = 0; k < 8 && k < got_id.size(); k++) begin
         check("stream_id",   WIDTH'(got_id[k]), WIDTH'(2));
         check("stream_data", got_data[k], {16'h0, 128'(k + 1)});
      end
      check("stream_count", WIDTH'(bus.msg_count), WIDTH'(8));

      // All-contend rotation from ptr = 0
      cyc('0, 1'b1, 1'b1);
      got_id.delete(); got_data.delete();
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < NREQ; i++) din[i] = {16'h0, 128'(i * 256 + k)};
         cyc(4'b1111, 1'b1, 1'b0);
      end
      check("rot_n", WIDTH'(got_id.size() >= 8), WIDTH'(1));
      for (int k = 0; k < 8 && k < got_id.size(); k++)
         check("rot_id", WIDTH'(got_id[k]), WIDTH'(k % NREQ));

      // Backpressure then lossless drain
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < NREQ; i++) din[i] = rand_msg();
         cyc(4'b1111, 1'b0, 1'b0);
      end
      repeat (8) cyc('0, 1'b1, 1'b0);
      check("bp_lossless", WIDTH'(bus.msg_count), WIDTH'(enq_total));

      // Enter on req 0 and write on req 1 held together with ptr = 0
      cyc('0, 1'b1, 1'b1);
      got_id.delete(); got_data.delete();
      din[0] = {16'h0, 128'hE0};
      din[1] = {16'h1, 128'hA1};
      cyc(4'b0011, 1'b1, 1'b0);
      repeat (4) cyc('0, 1'b1, 1'b0);
`ifdef LPM_ARB_WRITE_PRIORITY_EN
      exp_first = 1;
`else
      exp_first = 0;
`endif
      check("prio_n", WIDTH'(got_id.size()), WIDTH'(2));
      if (got_id.size() > 0) check("prio_first", WIDTH'(got_id[0]), WIDTH'(exp_first));

      // Random traffic
      cyc('0, 1'b1, 1'b1);
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < NREQ; i++) din[i] = rand_msg();
         cyc(NREQ'($urandom), logic'($urandom_range(0, 3) != 0), 1'b0);
      end
      repeat (8) cyc('0, 1'b1, 1'b0);
      check("rand_lossless", WIDTH'(bus.msg_count), WIDTH'(enq_total));

      // Reset while output valid and three holding registers full
      cyc('0, 1'b1, 1'b1);
      for (int i = 0; i < NREQ; i++) din[i] = rand_msg();
      cyc(4'b1111, 1'b0, 1'b0);
      cyc('0, 1'b0, 1'b0);
      check("mf_pre_valid", WIDTH'(bus.out_enq__ENA), WIDTH'(1));
      check("mf_pre_rdy",   WIDTH'(bus.req_enq__RDY), WIDTH'(4'b0001));
      cyc(4'b1111, 1'b0, 1'b1);
      check("mf_valid", WIDTH'(bus.out_enq__ENA), '0);
      check("mf_rdy",   WIDTH'(bus.req_enq__RDY), WIDTH'(4'b1111));
      check("mf_count", WIDTH'(bus.msg_count), '0);
      repeat (2) cyc('0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
